camera_capture: RTL and testbench
=================================

// Module: camera_capture
// PURPOSE
//  Camera-side front end of the vision pipeline. Takes OV7670 RGB565 byte stream (DATA/HREF/VSYNC, CLK = PCLK),
//  packs each byte pair into one RGB332 pixel, and writes it into the 176x144 M9K frame buffer.
//  The buffer is later read out via VGA_PIXEL_X/Y by the image processor / VGA path.
//  Also reports per-frame completion and geometry errors.
// PARAMETERS
//  WIDTH      176  pixels per line stored; extra pixels in a line are dropped
//  HEIGHT     144  lines per frame stored; extra lines are dropped
//  ADDR_W     15   frame-buffer address width (WIDTH*HEIGHT-1 = 25343 must fit)
//  LOW_FIRST  0    0: high byte (R[4:0],G[5:3]) arrives first; 1: low byte (G[2:0],B[4:0]) first
// PORTS
//  CLK         in   1       camera pixel clock; all logic on rising edge
//  RESET       in   1       asynchronous, active-high
//  DATA        in   8       camera data byte
//  HREF        in   1       high while a line's bytes are valid
//  VSYNC       in   1       high during vertical sync; rising edge ends a frame
//  PIXEL_OUT   out  8       RGB332 pixel {R[7:5],G[4:2],B[1:0]} for buffer write port
//  W_ADDR      out  ADDR_W  buffer write address = Y*WIDTH + X
//  W_EN        out  1       one-cycle write strobe for PIXEL_OUT/W_ADDR
//  FRAME_DONE  out  1       one-cycle pulse at end of each captured frame
//  FRAME_ERR   out  1       valid with FRAME_DONE, held until next FRAME_DONE
// BEHAVIOUR
//  Reset: all outputs 0; X=Y=0; byte phase=first; state SYNC_WAIT.
//  DATA/HREF/VSYNC are registered once (s1); edges are detected on s1 against its previous value.
//  FSM:
//   SYNC_WAIT: discards the partial frame after reset; VSYNC rise -> VBLANK.
//   VBLANK: clears X, Y, phase, error accumulator; VSYNC low -> ACTIVE.
//   ACTIVE: captures; VSYNC rise -> FRAME_DONE=1 for one cycle, FRAME_ERR updated -> VBLANK.
//  Byte packing, in ACTIVE with s1 HREF=1, phase toggles every cycle:
//   - High byte h: latch R=h[7:5], Ghi=h[2:0].
//   - Low byte l: PIXEL_OUT={R,Ghi,l[4:3]}.
//   - LOW_FIRST=1 swaps which byte is latched first; packing is otherwise identical.
//  Write strobe:
//   - W_EN=1 for one cycle, on the 2nd CLK edge after the edge sampling the second byte of a pair.
//   - Only issued if X<WIDTH and Y<HEIGHT.
//   - X increments per completed pair regardless of clipping; saturates at 2^9-1.
//  W_ADDR:
//   - Kept as a running counter, no multiplier.
//   - Increments after each issued write; the address skips nothing on clipping.
//   - Frame base is always 0.
//  HREF fall (s1), in ACTIVE:
//   - Y+=1 (saturates at 2^8-1), X=0, phase=first.
//   - Line error if X!=WIDTH or phase was mid-pair; a dangling byte is discarded.
//  FRAME_ERR at VSYNC rise = any line error this frame OR Y!=HEIGHT.
//  HREF high while VSYNC high: ignored.
//  VSYNC rise while HREF high: line closes as if HREF fell (counted, error checked), then frame ends.
//  RESET mid-frame: pending write is cancelled (W_EN low immediately); capture restarts at the next full frame.
// TESTING
//  1 Nominal frame, 144 lines x 176 px, LOW_FIRST=0 -> 25344 W_EN pulses, W_ADDR 0..25343 in order,
//    one FRAME_DONE, FRAME_ERR=0.
//  2 Packing: pairs (F8,1F),(07,E0),(00,18),(FF,FF) -> PIXEL_OUT E3,1C,03,FF;
//    repeat with LOW_FIRST=1 and bytes swapped -> same outputs.
//  3 Line of 180 px in row 10 -> row 10 gets 176 writes at 1760..1935, next row starts at 1936,
//    FRAME_ERR=1.
//  4 Line with 351 bytes -> 175 writes, last byte dropped, next line's addresses correct, FRAME_ERR=1.
//  5 150 lines -> no writes for Y>=144, last W_ADDR=25343, FRAME_ERR=1;
//    next nominal frame -> FRAME_ERR=0.
//  6 RESET asserted at row 50 -> no W_EN until a VSYNC rise then fall;
//    following frame captured from W_ADDR 0, no FRAME_DONE for the aborted frame.

Source files
------------

// File: rtl/camera_capture.sv
// OV7670 RGB565 byte stream to RGB332 frame-buffer writer.
// Packs byte pairs, clips to WIDTH x HEIGHT, and reports per-frame geometry errors.
module camera_capture #(
    parameter int unsigned WIDTH     = 176,
    parameter int unsigned HEIGHT    = 144,
    parameter int unsigned ADDR_W    = 15,
    parameter bit          LOW_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        DATA,
    input  logic              HREF,
    input  logic              VSYNC,
    output logic [7:0]        PIXEL_OUT,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);
    localparam logic [8:0] WidthX  = 9'(WIDTH);
    localparam logic [7:0] HeightY = 8'(HEIGHT);

    typedef enum logic [1:0] {StSyncWait, StVblank, StActive} state_e;
    state_e state_q, state_d;

    logic [7:0]        data_s1_q;
    logic              href_s1_q, vsync_s1_q, href_prev_q, vsync_prev_q;
    logic [8:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic              phase_q, phase_d;
    logic [7:0]        byte_q, byte_d;
    logic              err_acc_q, err_acc_d;
    logic              pend_q, pend_d;
    logic [7:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              w_en_q, w_en_d;
    logic [7:0]        pix_out_q, pix_out_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;

    logic       vsync_rise, line_close, capture, line_err;
    logic [7:0] hi_byte, lo_byte;
    logic       unused_bits;

    assign vsync_rise  = vsync_s1_q & ~vsync_prev_q;
    // A VSYNC rise with HREF still high closes the open line as well.
    assign line_close  = href_prev_q & (~href_s1_q | vsync_rise);
    assign capture     = href_s1_q & ~vsync_s1_q;
    assign hi_byte     = LOW_FIRST ? data_s1_q : byte_q;
    assign lo_byte     = LOW_FIRST ? byte_q : data_s1_q;
    assign unused_bits = ^{hi_byte[4:3], lo_byte[7:5], lo_byte[2:0]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StSyncWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSyncWait: if (vsync_rise) state_d = StVblank;
            StVblank:   if (!vsync_s1_q) state_d = StActive;
            StActive:   if (vsync_rise) state_d = StVblank;
            default:    state_d = StSyncWait;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        byte_d      = byte_q;
        err_acc_d   = err_acc_q;
        pend_d      = 1'b0;
        pix_d       = pix_q;
        addr_d      = addr_q;
        w_en_d      = pend_q;
        pix_out_d   = pend_q ? pix_q : pix_out_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        line_err    = 1'b0;

        if (w_en_q) addr_d = addr_q + ADDR_W'(1);

        unique case (state_q)
            StVblank: begin
                x_d       = '0;
                y_d       = '0;
                phase_d   = 1'b0;
                err_acc_d = 1'b0;
                // Only rewind once the last write of the previous frame has drained.
                if (!pend_q && !w_en_q) addr_d = '0;
            end
            StActive: begin
                if (capture) begin
                    if (!phase_q) begin
                        byte_d  = data_s1_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        pix_d   = {hi_byte[7:5], hi_byte[2:0], lo_byte[4:3]};
                        pend_d  = (x_q < WidthX) && (y_q < HeightY);
                        x_d     = (x_q == '1) ? x_q : x_q + 9'd1;
                    end
                end
                if (line_close) begin
                    line_err  = (x_q != WidthX) || phase_q;
                    y_d       = (y_q == '1) ? y_q : y_q + 8'd1;
                    x_d       = '0;
                    phase_d   = 1'b0;
                    err_acc_d = err_acc_q | line_err;
                end
                if (vsync_rise) begin
                    done_d      = 1'b1;
                    frame_err_d = err_acc_q | line_err | (y_d != HeightY);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_s1_q    <= '0;
            href_s1_q    <= 1'b0;
            vsync_s1_q   <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            phase_q      <= 1'b0;
            byte_q       <= '0;
            err_acc_q    <= 1'b0;
            pend_q       <= 1'b0;
            pix_q        <= '0;
            addr_q       <= '0;
            w_en_q       <= 1'b0;
            pix_out_q    <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_s1_q    <= DATA;
            href_s1_q    <= HREF;
            vsync_s1_q   <= VSYNC;
            href_prev_q  <= href_s1_q;
            vsync_prev_q <= vsync_s1_q;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            byte_q       <= byte_d;
            err_acc_q    <= err_acc_d;
            pend_q       <= pend_d;
            pix_q        <= pix_d;
            addr_q       <= addr_d;
            w_en_q       <= w_en_d;
            pix_out_q    <= pix_out_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign PIXEL_OUT  = pix_out_q;
    assign W_ADDR     = addr_q;
    assign W_EN       = w_en_q;
    assign FRAME_DONE = done_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture: two instances (LOW_FIRST=0/1) fed the same
// stream with pair-swapped bytes must produce identical, expected writes and frame flags.
module tb_camera_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data, data_lf;
    logic        href, vsync;
    logic [7:0]  pix0, pix1;
    logic [14:0] addr0, addr1;
    logic        wen0, wen1, done0, done1, err0, err1;

    always #5 clk = ~clk;

    camera_capture #(.LOW_FIRST(1'b0)) u_dut (
        .CLK(clk), .RESET(rst), .DATA(data), .HREF(href), .VSYNC(vsync),
        .PIXEL_OUT(pix0), .W_ADDR(addr0), .W_EN(wen0), .FRAME_DONE(done0), .FRAME_ERR(err0)
    );

    camera_capture #(.LOW_FIRST(1'b1)) u_dut_lf (
        .CLK(clk), .RESET(rst), .DATA(data_lf), .HREF(href), .VSYNC(vsync),
        .PIXEL_OUT(pix1), .W_ADDR(addr1), .W_EN(wen1), .FRAME_DONE(done1), .FRAME_ERR(err1)
    );

    typedef struct packed {logic [14:0] addr; logic [7:0] pix;} wr_t;
    typedef struct packed {logic err; int nwr; int last;} fr_t;

    wr_t wq[$];
    fr_t fq[$];
    wr_t we;
    fr_t fe;
    int  checks = 0;
    int  errors = 0;
    int  nwr = 0;
    int  last = -1;
    int  mx = 0, my = 0, maddr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got event at addr %0d, expected none", name, act);
    endtask

    function automatic logic [7:0] pack(input logic [7:0] h, input logic [7:0] l);
        return {h[7:5], h[2:0], l[4:3]};
    endfunction

    // Monitor: pops the scoreboard whenever either DUT writes or ends a frame.
    always @(negedge clk) begin
        if (rst) begin
            nwr  = 0;
            last = -1;
        end else begin
            if (wen0 || wen1) begin
                chk("wen_both", int'({wen0, wen1}), 3);
                if (wq.size() == 0) begin
                    flag("write_unexpected", int'(addr0));
                end else begin
                    we = wq.pop_front();
                    chk("w_addr", int'(addr0), int'(we.addr));
                    chk("pixel", int'(pix0), int'(we.pix));
                    chk("w_addr_lf", int'(addr1), int'(we.addr));
                    chk("pixel_lf", int'(pix1), int'(we.pix));
                end
                nwr++;
                last = int'(addr0);
            end
            if (done0 || done1) begin
                chk("done_both", int'({done0, done1}), 3);
                if (fq.size() == 0) begin
                    flag("frame_done_unexpected", last);
                end else begin
                    fe = fq.pop_front();
                    chk("frame_err", int'(err0), int'(fe.err));
                    chk("frame_err_lf", int'(err1), int'(fe.err));
                    chk("frame_writes", nwr, fe.nwr);
                    chk("frame_last_addr", last, fe.last);
                end
                nwr  = 0;
                last = -1;
            end
        end
    end

    task automatic drive(input logic h, input logic [7:0] d, input logic [7:0] dlf);
        href    = h;
        data    = d;
        data_lf = dlf;
        @(negedge clk);
    endtask

    task automatic send_pair(input logic [7:0] h, input logic [7:0] l, input bit model);
        drive(1'b1, h, l);
        drive(1'b1, l, h);
        if (model) begin
            if (mx < 176 && my < 144) begin
                wq.push_back('{addr: 15'(maddr), pix: pack(h, l)});
                maddr++;
            end
            mx++;
        end
    endtask

    task automatic end_line(input bit model);
        drive(1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        if (model) my++;
        mx = 0;
    endtask

    task automatic send_line(input int npix, input bit odd, input int seed, input bit model);
        for (int i = 0; i < npix; i++) begin
            send_pair(8'(i * 7 + seed), 8'(i * 13 + seed * 3), model);
        end
        if (odd) drive(1'b1, 8'hA5, 8'hA5);
        end_line(model);
    endtask

    task automatic vsync_pulse();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        mx    = 0;
        my    = 0;
        maddr = 0;
    endtask

    task automatic end_frame(input logic err, input int n, input int lst);
        fq.push_back('{err: err, nwr: n, last: lst});
        vsync_pulse();
        chk("frame_err_held", int'(err0), int'(err));
        chk("frame_err_held_lf", int'(err1), int'(err));
    endtask

    initial begin
        rst = 1'b1; data = '0; data_lf = '0; href = 1'b0; vsync = 1'b0;
        #1;
        chk("rst_w_en", int'({wen0, wen1}), 0);
        chk("rst_w_addr", int'(addr0) + int'(addr1), 0);
        chk("rst_pixel", int'(pix0) + int'(pix1), 0);
        chk("rst_done", int'({done0, done1}), 0);
        chk("rst_err", int'({err0, err1}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Partial frame after reset is discarded, then sync.
        send_line(4, 1'b0, 1, 1'b0);
        vsync_pulse();

        // Packing vectors.
        wq.push_back('{addr: 15'd0, pix: 8'hE3});
        wq.push_back('{addr: 15'd1, pix: 8'h1C});
        wq.push_back('{addr: 15'd2, pix: 8'h03});
        wq.push_back('{addr: 15'd3, pix: 8'hFF});
        send_pair(8'hF8, 8'h1F, 1'b0);
        send_pair(8'h07, 8'hE0, 1'b0);
        send_pair(8'h00, 8'h18, 1'b0);
        send_pair(8'hFF, 8'hFF, 1'b0);
        end_line(1'b0);
        end_frame(1'b1, 4, 3);

        // Long row 10 (180 px) then a 351-byte row, then a normal row.
        for (int r = 0; r < 10; r++) send_line(176, 1'b0, r, 1'b1);
        send_line(180, 1'b0, 10, 1'b1);
        send_line(175, 1'b1, 11, 1'b1);
        send_line(176, 1'b0, 12, 1'b1);
        end_frame(1'b1, 2287, 2286);

        // 150 short lines: rows 144..149 produce nothing.
        for (int r = 0; r < 150; r++) send_line(4, 1'b0, r, 1'b1);
        end_frame(1'b1, 576, 575);

        // Nominal full frame.
        for (int r = 0; r < 144; r++) send_line(176, 1'b0, r, 1'b1);
        end_frame(1'b0, 25344, 25343);

        // Reset at row 50 with a write in flight.
        for (int r = 0; r < 50; r++) send_line(4, 1'b0, r, 1'b1);
        drive(1'b1, 8'h12, 8'h34);
        drive(1'b1, 8'h34, 8'h12);
        drive(1'b1, 8'h56, 8'h56);
        rst = 1'b1;
        #1;
        chk("midrst_w_en", int'({wen0, wen1}), 0);
        chk("midrst_w_addr", int'(addr0) + int'(addr1), 0);
        chk("midrst_err", int'({err0, err1}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int r = 51; r < 60; r++) send_line(4, 1'b0, r, 1'b0);
        vsync_pulse();
        for (int r = 0; r < 3; r++) send_line(4, 1'b0, r + 90, 1'b1);
        end_frame(1'b1, 12, 11);

        repeat (4) @(negedge clk);
        chk("writes_outstanding", wq.size(), 0);
        chk("frames_outstanding", fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
